// File: rtl/pio_arb_pkg.sv
// Shared types for the PIO Avalon arbiter.
// FSM encoding and master indices.
package pio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker.
// Ties go to the master that was not served last.
module rr_arb2
  import pio_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner,
  output logic       any_req
);

  // Pick the winner from the request pair and the last grant
  always_comb begin
    any_req = |req;
    winner  = M0;
    case (req)
      2'b11:   winner = ~last_grant;
      2'b10:   winner = M1;
      default: winner = M0;
    endcase
  end

endmodule

// File: rtl/pio_avalon_arbiter.sv
// Two-master round-robin arbiter in front of a
// zero-wait PIO slave, one transfer per grant.
module pio_avalon_arbiter
  import pio_arb_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_chipselect,
  output logic              s_write_n,
  output logic [DATA_W-1:0] s_writedata,
  input  logic [DATA_W-1:0] s_readdata,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
);

  state_t            state;
  state_t            state_nx;
  logic              grant;
  logic              last_grant;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_wr;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [15:0]       cnt0;
  logic [15:0]       cnt1;
  logic [1:0]        req;
  logic              winner;
  logic              any_req;
  logic              in_access;
  logic              in_done;
  logic              take;

  assign req = {m1_read | m1_write,
                m0_read | m0_write};

  rr_arb2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign m0_readdata = rdata0;
  assign m1_readdata = rdata1;
  assign grant_cnt0  = cnt0;
  assign grant_cnt1  = cnt1;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state and slave/master handshake outputs
  always_comb begin
    state_nx       = IDLE;
    in_access      = 1'b0;
    in_done        = 1'b0;
    take           = 1'b0;
    case (state)
      IDLE: begin
        take     = any_req;
        state_nx = any_req ? ACCESS : IDLE;
      end
      ACCESS: begin
        in_access = 1'b1;
        state_nx  = DONE;
      end
      DONE: begin
        in_done  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    s_chipselect   = in_access;
    s_write_n      = ~(in_access & cmd_wr);
    s_address      = in_access ? cmd_addr : '0;
    s_writedata    = in_access ? cmd_data : '0;
    m0_waitrequest = ~(in_done & (grant == M0));
    m1_waitrequest = ~(in_done & (grant == M1));
  end

  // Latch the winning master's command on grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant    <= M0;
      cmd_addr <= '0;
      cmd_data <= '0;
      cmd_wr   <= 1'b0;
    end else if (take) begin
      grant    <= winner;
      cmd_addr <= winner ? m1_address : m0_address;
      cmd_data <= winner ? m1_writedata : m0_writedata;
      cmd_wr   <= winner ? m1_write : m0_write;
    end
  end

  // Capture PIO read data for the granted master
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (in_access && !cmd_wr) begin
      if (grant == M0) rdata0 <= s_readdata;
      else             rdata1 <= s_readdata;
    end
  end

  // Close the transfer: rotate priority, count it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= M1;
      cnt0       <= '0;
      cnt1       <= '0;
    end else if (in_done) begin
      last_grant <= grant;
      if (grant == M0) cnt0 <= cnt0 + 16'd1;
      else             cnt1 <= cnt1 + 16'd1;
    end
  end

endmodule
